enc_pwm_mixer: RTL and testbench

Parametrised N-channel successor to the three-channel RGB mixer: each channel takes a quadrature rotary encoder pair, debounces it, decodes it into a WIDTH-bit level and drives a PWM output at that duty cycle. Everything runs on the single system clock, gated by an internal sample-tick enable, so no logic is clocked from a derived clock. The block sits at the top of the LED mixer design, between the encoder pins and the LED driver pins.

---
 rtl/enc_pwm_mixer.sv | 131 +++++++++++++
 tb/tb_enc_pwm_mixer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_pwm_mixer.sv
// ============================================================================
// Module   : enc_pwm_mixer
// Brief    : N-channel quadrature encoder -> debounced level -> PWM mixer.
//            Optional macro LEVEL_SATURATE_EN clamps level instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_pwm_mixer #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 256,
  parameter int DB_COUNT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         enc_a,
  input  logic [CHANNELS-1:0]         enc_b,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic [CHANNELS*WIDTH-1:0]   level
);

  localparam int                  c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]          c_DB_LAST   = 8'(DB_COUNT - 1);
  localparam logic [WIDTH-1:0]    c_LEVEL_MAX = '1;
  localparam int                  c_INPUTS    = 2 * CHANNELS;

  logic [CHANNELS-1:0] r_sync_a1, r_sync_a2, r_sync_b1, r_sync_b2;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [WIDTH-1:0]    r_pwm_cnt;
  logic                w_tick;
  logic [c_INPUTS-1:0] w_sync;
  logic [c_INPUTS-1:0] w_db_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_a1  <= '0;
      r_sync_a2  <= '0;
      r_sync_b1  <= '0;
      r_sync_b2  <= '0;
      r_tick_cnt <= '0;
      r_pwm_cnt  <= '0;
    end else begin
      r_sync_a1  <= enc_a;
      r_sync_a2  <= r_sync_a1;
      r_sync_b1  <= enc_b;
      r_sync_b2  <= r_sync_b1;
      r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == c_TICK_LAST);
  assign w_sync = {r_sync_b2, r_sync_a2};

  // Inputs [CHANNELS-1:0] are A phases, the upper half are B phases.
  // w_db_nxt is the debounced value as it will be after this edge, so the
  // decoder can act in the same tick cycle the debounced value changes.
  genvar j;
  generate
    for (j = 0; j < c_INPUTS; j++) begin : g_db
      logic [7:0] r_cnt;
      logic       r_db;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (w_tick) begin
          if (w_sync[j] == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_db  <= w_sync[j];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end

      assign w_db_nxt[j] = (w_tick && (w_sync[j] != r_db) && (r_cnt == c_DB_LAST))
                           ? w_sync[j] : r_db;
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic             r_prev_a;
      logic [WIDTH-1:0] r_level;
      logic             r_pwm;
      logic             w_rise;
      logic             w_down;

      assign w_rise = w_tick && !r_prev_a && w_db_nxt[i];
      assign w_down = w_db_nxt[CHANNELS + i];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_prev_a <= 1'b0;
          r_level  <= '0;
        end else if (w_tick) begin
          r_prev_a <= w_db_nxt[i];
          if (w_rise) begin
`ifdef LEVEL_SATURATE_EN
            if (w_down) begin
              if (r_level != '0) r_level <= r_level - 1'b1;
            end else begin
              if (r_level != c_LEVEL_MAX) r_level <= r_level + 1'b1;
            end
`else
            r_level <= w_down ? r_level - 1'b1 : r_level + 1'b1;
`endif
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) r_pwm <= 1'b0;
        else       r_pwm <= (r_pwm_cnt < r_level);
      end

      assign level[i*WIDTH +: WIDTH] = r_level;
      assign pwm_out[i]              = r_pwm;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_enc_pwm_mixer.sv
// ============================================================================
// Module   : tb_enc_pwm_mixer
// Brief    : Self-checking bench for enc_pwm_mixer (CHANNELS=3, WIDTH=8,
//            TICK_DIV=4, DB_COUNT=3); honours LEVEL_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enc_pwm_mixer;

  localparam int CHANNELS = 3;
  localparam int WIDTH    = 8;
  localparam int TICK_DIV = 4;
  localparam int DB_COUNT = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS-1:0]       enc_a, enc_b;
  logic [CHANNELS-1:0]       pwm_out;
  logic [CHANNELS*WIDTH-1:0] level;

  int checks   = 0;
  int failures = 0;
  int exp_level [CHANNELS];

  always #5 clk = ~clk;

  enc_pwm_mixer #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV),
    .DB_COUNT (DB_COUNT)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .pwm_out (pwm_out),
    .level   (level)
  );

  function automatic int step(input int l, input bit down);
`ifdef LEVEL_SATURATE_EN
    if (down) return (l == 0) ? 0 : l - 1;
    else      return (l == 255) ? 255 : l + 1;
`else
    return down ? (l + 255) % 256 : (l + 1) % 256;
`endif
  endfunction

  function automatic logic [23:0] exp_vec();
    return {exp_level[2][7:0], exp_level[1][7:0], exp_level[0][7:0]};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    enc_a = '0;
    enc_b = '0;
    reset = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    for (int i = 0; i < CHANNELS; i++) exp_level[i] = 0;
  endtask

  // Clean B setup, clean A rise held well past the debounce time, clean fall.
  task automatic pulse(input logic [2:0] mask, input logic [2:0] b);
    enc_b = b;
    wait_clk(20);
    enc_a = mask;
    wait_clk(20);
    enc_a = '0;
    wait_clk(20);
    for (int i = 0; i < CHANNELS; i++)
      if (mask[i]) exp_level[i] = step(exp_level[i], b[i]);
  endtask

  task automatic test_reset();
    enc_a = 3'($urandom);
    enc_b = 3'($urandom);
    wait_clk(10);
    reset = 1'b1;
    wait_clk(1);
    checks++;
    if (level !== 24'h0) begin
      failures++;
      $display("FAIL reset_level: got %h expected %h", level, 24'h0);
    end
    checks++;
    if (pwm_out !== 3'b000) begin
      failures++;
      $display("FAIL reset_pwm: got %b expected %b", pwm_out, 3'b000);
    end
    enc_a = '0;
    enc_b = '0;
    wait_clk(3);
    reset = 1'b0;
    for (int i = 0; i < CHANNELS; i++) exp_level[i] = 0;
  endtask

  // First tick 4 clk after reset release; three ticks of debounce -> level
  // moves on the 12th edge after release.
  task automatic test_increment();
    enc_b = '0;
    enc_a = 3'b001;
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    for (int i = 0; i < CHANNELS; i++) exp_level[i] = 0;
    for (int k = 1; k <= 12; k++) begin
      wait_clk(1);
      if (k == 11) begin
        checks++;
        if (level !== 24'h0) begin
          failures++;
          $display("FAIL inc_early: got %h expected %h at edge 11", level, 24'h0);
        end
      end
    end
    exp_level[0] = step(0, 1'b0);
    checks++;
    if (level !== exp_vec()) begin
      failures++;
      $display("FAIL inc_edge12: got %h expected %h", level, exp_vec());
    end
    enc_a = '0;
    wait_clk(20);
    checks++;
    if (level !== exp_vec()) begin
      failures++;
      $display("FAIL inc_after_fall: got %h expected %h", level, exp_vec());
    end
  endtask

  task automatic test_decrement_wrap();
    pulse(3'b010, 3'b010);
    checks++;
    if (level !== exp_vec()) begin
      failures++;
      $display("FAIL dec_wrap: got %h expected %h", level, exp_vec());
    end
  endtask

  task automatic test_glitch();
    enc_b = '0;
    wait_clk(20);
    enc_a = 3'b100;
    wait_clk(6);
    enc_a = '0;
    wait_clk(20);
    checks++;
    if (level !== exp_vec()) begin
      failures++;
      $display("FAIL glitch_reject: got %h expected %h", level, exp_vec());
    end
    pulse(3'b100, 3'b000);
    checks++;
    if (level !== exp_vec()) begin
      failures++;
      $display("FAIL glitch_long: got %h expected %h", level, exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    bit seen;
    do_reset();
    enc_b = 3'b010;
    wait_clk(20);
    enc_a = 3'b111;
    seen  = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      wait_clk(1);
      if (level !== 24'h0) seen = 1'b1;
    end
    exp_level[0] = step(0, 1'b0);
    exp_level[1] = step(0, 1'b1);
    exp_level[2] = step(0, 1'b0);
    checks++;
    if (!seen || level !== exp_vec()) begin
      failures++;
      $display("FAIL simultaneous: got %h expected %h (seen=%0d)", level, exp_vec(), seen);
    end
    enc_a = '0;
    wait_clk(20);
  endtask

  task automatic test_pwm_duty();
    int cnt;
    do_reset();
    repeat (64) pulse(3'b001, 3'b000);
    checks++;
    if (level[7:0] !== 8'(exp_level[0])) begin
      failures++;
      $display("FAIL pwm_level64: got %0d expected %0d", level[7:0], exp_level[0]);
    end
    for (int w = 0; w < 2; w++) begin
      cnt = 0;
      for (int k = 0; k < 256; k++) begin
        wait_clk(1);
        if (pwm_out[0]) cnt++;
      end
      checks++;
      if (cnt != 64) begin
        failures++;
        $display("FAIL pwm_duty64 window %0d: got %0d high expected %0d", w, cnt, 64);
      end
    end
    do_reset();
    cnt = 0;
    for (int k = 0; k < 512; k++) begin
      wait_clk(1);
      if (pwm_out[0]) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL pwm_level0: got %0d high expected 0", cnt);
    end
  endtask

  task automatic test_random();
    logic [2:0] mask, b;
    int cnt [CHANNELS];
    for (int r = 0; r < 12; r++) begin
      mask = 3'($urandom_range(1, 7));
      b    = 3'($urandom);
      pulse(mask, b);
      checks++;
      if (level !== exp_vec()) begin
        failures++;
        $display("FAIL random_round %0d: got %h expected %h", r, level, exp_vec());
      end
    end
    for (int i = 0; i < CHANNELS; i++) cnt[i] = 0;
    for (int k = 0; k < 256; k++) begin
      wait_clk(1);
      for (int i = 0; i < CHANNELS; i++) if (pwm_out[i]) cnt[i]++;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      checks++;
      if (cnt[i] != exp_level[i]) begin
        failures++;
        $display("FAIL random_duty ch%0d: got %0d high expected %0d", i, cnt[i], exp_level[i]);
      end
    end
  endtask

  // Pending debounce progress must be dropped: the rise restarts from zero.
  task automatic test_reset_mid();
    enc_b = '0;
    wait_clk(20);
    enc_a = 3'b001;
    wait_clk(10);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    for (int i = 0; i < CHANNELS; i++) exp_level[i] = 0;
    for (int k = 1; k <= 12; k++) begin
      wait_clk(1);
      if (k == 11) begin
        checks++;
        if (level !== 24'h0) begin
          failures++;
          $display("FAIL reset_mid_early: got %h expected %h", level, 24'h0);
        end
      end
    end
    exp_level[0] = step(0, 1'b0);
    checks++;
    if (level !== exp_vec()) begin
      failures++;
      $display("FAIL reset_mid_edge12: got %h expected %h", level, exp_vec());
    end
    enc_a = '0;
    wait_clk(20);
  endtask

  initial begin
    reset = 1'b1;
    enc_a = '0;
    enc_b = '0;
    for (int i = 0; i < CHANNELS; i++) exp_level[i] = 0;
    wait_clk(4);
    reset = 1'b0;
    test_reset();
    test_increment();
    test_decrement_wrap();
    test_glitch();
    test_simultaneous();
    test_pwm_duty();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
